// File: rtl/uart_tx_framer.sv
// uart_tx_framer: async serial framer fed by the UART TX prescaler.
// A bit boundary is any clk where the prescaler count q_in is zero. Bytes
// enter a one-deep holding register over valid/ready and leave LSB-first
// as start, data, optional parity, stop. Back-to-back frames are seamless.
// Optional even-parity bit: define UART_TX_PARITY_EN to compile it in.
module uart_tx_framer #(
    parameter int N         = 13,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         q_in,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                 state_reg, state_next;
    logic [DATA_BITS-1:0]   hold_reg;
    logic                   hold_full_reg;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic                   stop_cnt_reg, stop_cnt_next;
    logic                   tx_reg, tx_next;
    logic                   frame_done_reg, frame_done_next;
    logic                   tick;
    logic                   load;
`ifdef UART_TX_PARITY_EN
    logic                   parity_reg;
`endif

    assign tick       = (q_in == '0);
    assign in_ready   = !hold_full_reg;
    assign tx         = tx_reg;
    assign busy       = (state_reg != IDLE);
    assign frame_done = frame_done_reg;

    // Holding register: capture on handshake, empty when the shifter takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
        end else if (in_valid && in_ready) begin
            hold_reg      <= in_data;
            hold_full_reg <= 1'b1;
        end else if (load) begin
            hold_full_reg <= 1'b0;
        end
    end

    // Framer state registers; reset drops tx high immediately, aborting any frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            idx_reg        <= '0;
            stop_cnt_reg   <= 1'b0;
            tx_reg         <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            idx_reg        <= idx_next;
            stop_cnt_reg   <= stop_cnt_next;
            tx_reg         <= tx_next;
            frame_done_reg <= frame_done_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the byte is latched when it is loaded into the shifter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_reg <= 1'b0;
        end else if (load) begin
            parity_reg <= ^hold_reg;
        end
    end
`endif

    // Next-state and output logic; everything holds unless this clk is a bit boundary.
    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        idx_next        = idx_reg;
        stop_cnt_next   = stop_cnt_reg;
        tx_next         = tx_reg;
        frame_done_next = 1'b0;
        load            = 1'b0;
        if (tick) begin
            case (state_reg)
                IDLE: begin
                    if (hold_full_reg) begin
                        load       = 1'b1;
                        shift_next = hold_reg;
                        tx_next    = 1'b0;
                        state_next = START;
                    end
                end
                START: begin
                    tx_next    = shift_reg[0];
                    idx_next   = '0;
                    state_next = DATA;
                end
                DATA: begin
                    if (idx_reg != LAST_IDX) begin
                        shift_next = shift_reg >> 1;
                        tx_next    = shift_reg[1];
                        idx_next   = idx_reg + IDX_W'(1);
                    end else begin
`ifdef UART_TX_PARITY_EN
                        tx_next       = parity_reg;
                        state_next    = PARITY;
`else
                        tx_next       = 1'b1;
                        stop_cnt_next = 1'b0;
                        state_next    = STOP;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    tx_next       = 1'b1;
                    stop_cnt_next = 1'b0;
                    state_next    = STOP;
                end
`endif
                STOP: begin
                    if (STOP_BITS == 2 && !stop_cnt_reg) begin
                        stop_cnt_next = 1'b1;
                    end else begin
                        frame_done_next = 1'b1;
                        if (hold_full_reg) begin
                            // Next byte already waiting: start bit follows with no idle gap.
                            load       = 1'b1;
                            shift_next = hold_reg;
                            tx_next    = 1'b0;
                            state_next = START;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Testbench for uart_tx_framer: prescaler model N=4, bitTime=3 (4 clk per bit).
// dut1 uses STOP_BITS=1, dut2 uses STOP_BITS=2; both DATA_BITS=8.
// Expectations follow UART_TX_PARITY_EN when the bench is built with it.
module tb_uart_tx_framer;

`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] q   = 4'd3;
    logic [7:0] din = 8'h00;
    logic       vld = 1'b0;
    logic       sel = 1'b0;

    logic vld1, rdy1, tx1, busy1, fd1;
    logic vld2, rdy2, tx2, busy2, fd2;
    logic tx_m, rdy_m, busy_m, fd_m;

    int tests = 0;
    int fails = 0;

    logic [63:0] cap_bits;
    int          cap_fd, cap_busy_low, cap_rdy_hi;
    logic        cap_rdy_inj;

    assign vld1   = vld & ~sel;
    assign vld2   = vld & sel;
    assign tx_m   = sel ? tx2   : tx1;
    assign rdy_m  = sel ? rdy2  : rdy1;
    assign busy_m = sel ? busy2 : busy1;
    assign fd_m   = sel ? fd2   : fd1;

    uart_tx_framer #(.N(4), .DATA_BITS(8), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .q_in(q), .in_data(din), .in_valid(vld1),
        .in_ready(rdy1), .tx(tx1), .busy(busy1), .frame_done(fd1)
    );

    uart_tx_framer #(.N(4), .DATA_BITS(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .q_in(q), .in_data(din), .in_valid(vld2),
        .in_ready(rdy2), .tx(tx2), .busy(busy2), .frame_done(fd2)
    );

    always #5 clk = ~clk;

    // Prescaler model: free-running down-counter 3,2,1,0.
    always @(posedge clk) q <= (q == 4'd0) ? 4'd3 : q - 4'd1;

    // Present one byte for one clk; caller ensures in_ready is high.
    task automatic send(input logic [7:0] d);
        din = d;
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
    endtask

    // Poll (bounded) for the start bit; returns at the negedge it first shows.
    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (tx_m === 1'b0) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    // Record tx at each bit start plus per-cycle status counts; optionally
    // offers a byte during the first bit period.
    task automatic capture(input int nbits, input bit inj, input logic [7:0] inj_data);
        cap_bits = '0; cap_fd = 0; cap_busy_low = 0; cap_rdy_hi = 0; cap_rdy_inj = 1'b1;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 0) cap_bits[b] = tx_m;
                if (fd_m) cap_fd++;
                if (!busy_m) cap_busy_low++;
                if (rdy_m) cap_rdy_hi++;
                if (inj && b == 0 && c == 0) begin din = inj_data; vld = 1'b1; end
                if (inj && b == 0 && c == 1) begin vld = 1'b0; cap_rdy_inj = rdy_m; end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (tx1 !== 1'b1)   begin fails++; $display("FAIL reset_tx: got %b expected 1", tx1); end
        tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy1); end
        tests++; if (rdy1 !== 1'b1)  begin fails++; $display("FAIL reset_ready: got %b expected 1", rdy1); end
        tests++; if (fd1 !== 1'b0)   begin fails++; $display("FAIL reset_frame_done: got %b expected 0", fd1); end
        tests++; if (tx2 !== 1'b1)   begin fails++; $display("FAIL reset_tx_dut2: got %b expected 1", tx2); end
        rst = 1'b1;
        @(negedge clk);
        $display("[TB] reset: tx=%b busy=%b ready=%b", tx1, busy1, rdy1);
    endtask

    task automatic test_single;
        bit ok;
        logic [63:0] exp;
        sel = 1'b0;
        if (PB != 0) exp = 64'({1'b1, 1'b0, 8'hA5, 1'b0});
        else         exp = 64'({1'b1, 8'hA5, 1'b0});
        tests++; if (rdy_m !== 1'b1) begin fails++; $display("FAIL single_ready: got %b expected 1", rdy_m); end
        send(8'hA5);
        wait_start(ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL single_start_timeout: got %b expected 1", ok); end
        capture(10 + PB, 1'b0, 8'h00);
        tests++; if (cap_bits !== exp) begin fails++; $display("FAIL single_bits: got %0h expected %0h", cap_bits, exp); end
        tests++; if (cap_fd !== 0) begin fails++; $display("FAIL single_early_done: got %0d expected 0", cap_fd); end
        tests++; if (cap_busy_low !== 0) begin fails++; $display("FAIL single_busy_gap: got %0d expected 0", cap_busy_low); end
        tests++; if (fd_m !== 1'b1) begin fails++; $display("FAIL single_done_pulse: got %b expected 1", fd_m); end
        tests++; if (busy_m !== 1'b0) begin fails++; $display("FAIL single_busy_fall: got %b expected 0", busy_m); end
        @(negedge clk);
        tests++; if (fd_m !== 1'b0) begin fails++; $display("FAIL single_done_width: got %b expected 0", fd_m); end
        $display("[TB] single 0xA5: bits=%0h", cap_bits);
    endtask

    task automatic test_parity;
        bit ok;
        logic [63:0] exp;
        sel = 1'b0;
        if (PB != 0) exp = 64'({1'b1, 1'b1, 8'h07, 1'b0});
        else         exp = 64'({1'b1, 8'h07, 1'b0});
        send(8'h07);
        wait_start(ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL parity_start_timeout: got %b expected 1", ok); end
        capture(10 + PB, 1'b0, 8'h00);
        tests++; if (cap_bits !== exp) begin fails++; $display("FAIL parity_bits: got %0h expected %0h", cap_bits, exp); end
        tests++; if (fd_m !== 1'b1) begin fails++; $display("FAIL parity_done: got %b expected 1", fd_m); end
        @(negedge clk);
        $display("[TB] byte 0x07: bits=%0h", cap_bits);
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [63:0] exp;
        sel = 1'b0;
        if (PB != 0) exp = 64'({1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0});
        else         exp = 64'({1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0});
        send(8'h00);
        wait_start(ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL b2b_start_timeout: got %b expected 1", ok); end
        capture(2 * (10 + PB), 1'b1, 8'hFF);
        tests++; if (cap_rdy_inj !== 1'b0) begin fails++; $display("FAIL b2b_ready_low: got %b expected 0", cap_rdy_inj); end
        tests++; if (cap_bits !== exp) begin fails++; $display("FAIL b2b_bits: got %0h expected %0h", cap_bits, exp); end
        tests++; if (cap_fd !== 1) begin fails++; $display("FAIL b2b_mid_done: got %0d expected 1", cap_fd); end
        tests++; if (cap_busy_low !== 0) begin fails++; $display("FAIL b2b_idle_gap: got %0d expected 0", cap_busy_low); end
        tests++; if (fd_m !== 1'b1) begin fails++; $display("FAIL b2b_final_done: got %b expected 1", fd_m); end
        tests++; if (busy_m !== 1'b0) begin fails++; $display("FAIL b2b_busy_fall: got %b expected 0", busy_m); end
        @(negedge clk);
        $display("[TB] back-to-back 0x00,0xFF: bits=%0h", cap_bits);
    endtask

    task automatic test_stop2;
        bit ok;
        logic [63:0] exp1, exp2;
        sel = 1'b1;
        if (PB != 0) begin
            exp1 = 64'({2'b11, 1'b0, 8'h81, 1'b0});
            exp2 = 64'({2'b11, 1'b0, 8'h3C, 1'b0});
        end else begin
            exp1 = 64'({2'b11, 8'h81, 1'b0});
            exp2 = 64'({2'b11, 8'h3C, 1'b0});
        end
        @(negedge clk);
        din = 8'h81;
        vld = 1'b1;
        @(negedge clk);
        tests++; if (rdy_m !== 1'b0) begin fails++; $display("FAIL stop2_first_accept: got %b expected 0", rdy_m); end
        wait_start(ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL stop2_start_timeout: got %b expected 1", ok); end
        capture(11 + PB, 1'b1, 8'h3C);
        tests++; if (cap_bits !== exp1) begin fails++; $display("FAIL stop2_bits: got %0h expected %0h", cap_bits, exp1); end
        tests++; if (cap_rdy_hi !== 1) begin fails++; $display("FAIL stop2_ready_cycles: got %0d expected 1", cap_rdy_hi); end
        tests++; if (cap_fd !== 0) begin fails++; $display("FAIL stop2_early_done: got %0d expected 0", cap_fd); end
        tests++; if (fd_m !== 1'b1) begin fails++; $display("FAIL stop2_done: got %b expected 1", fd_m); end
        capture(11 + PB, 1'b0, 8'h00);
        tests++; if (cap_bits !== exp2) begin fails++; $display("FAIL stop2_queued_bits: got %0h expected %0h", cap_bits, exp2); end
        tests++; if (busy_m !== 1'b0) begin fails++; $display("FAIL stop2_busy_end: got %b expected 0", busy_m); end
        @(negedge clk);
        $display("[TB] stop2 0x81 + queued 0x3C: bits=%0h", cap_bits);
        sel = 1'b0;
    endtask

    task automatic test_align;
        bit found;
        logic [63:0] exp;
        sel = 1'b0;
        if (PB != 0) exp = 64'({1'b1, 1'b0, 8'h5A, 1'b0});
        else         exp = 64'({1'b1, 8'h5A, 1'b0});
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (q == 4'd0) found = 1'b1;
        end
        @(negedge clk);
        send(8'h5A);
        @(negedge clk);
        @(negedge clk);
        tests++; if (tx_m !== 1'b1) begin fails++; $display("FAIL align_early_start: got %b expected 1", tx_m); end
        @(negedge clk);
        tests++; if (tx_m !== 1'b0) begin fails++; $display("FAIL align_start_3clk: got %b expected 0", tx_m); end
        capture(10 + PB, 1'b0, 8'h00);
        tests++; if (cap_bits !== exp) begin fails++; $display("FAIL align_bits: got %0h expected %0h", cap_bits, exp); end
        @(negedge clk);
        $display("[TB] aligned 0x5A: bits=%0h", cap_bits);
    endtask

    task automatic test_reset_midframe;
        bit ok;
        int low_cnt;
        sel = 1'b0;
        send(8'h00);
        wait_start(ok);
        capture(3, 1'b1, 8'hFF);
        tests++; if (tx_m !== 1'b0) begin fails++; $display("FAIL midrst_precondition: got %b expected 0", tx_m); end
        rst = 1'b0;
        #1;
        tests++; if (tx1 !== 1'b1)   begin fails++; $display("FAIL midrst_tx_async: got %b expected 1", tx1); end
        tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL midrst_idle: got %b expected 0", busy1); end
        tests++; if (rdy1 !== 1'b1)  begin fails++; $display("FAIL midrst_hold_clear: got %b expected 1", rdy1); end
        @(negedge clk);
        rst = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || busy1 !== 1'b0) low_cnt++;
        end
        tests++; if (low_cnt !== 0) begin fails++; $display("FAIL midrst_no_resume: got %0d active cycles expected 0", low_cnt); end
        $display("[TB] reset mid-frame: tx=%b busy=%b ready=%b", tx1, busy1, rdy1);
    endtask

    initial begin
        test_reset;
        test_single;
        test_parity;
        test_back_to_back;
        test_stop2;
        test_align;
        test_reset_midframe;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
